pwm_capture: RTL and testbench

- Receiver for the team's PWM generator waveform: measures the high time and period of an incoming PWM signal in clk cycles.
- Reports them as cmp/top values in the generator's own encoding, so writing them back through the generator's cmp/top load path reproduces the measured waveform.
- Sits at a chip input (servo/fan tach, loopback test) in front of a register/readback bus.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_in_sync.sv | 62 ++++++
 rtl/pwm_capture.sv | 134 +++++++++++++
 tb/tb_pwm_capture.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM types: capture FSM states and the default counter width used by
// both the generator and the capture block.
package pwm_pkg;

    localparam int PWM_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for pwm_capture: synchronizer chain, optional glitch filter
// (PWM_CAP_FILT_EN), and a registered level/rise pair aligned to each other.
module pwm_in_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise
);

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_chk
        $error("pwm_in_sync: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end

`ifdef PWM_CAP_FILT_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] filt_cnt;
    logic          filt_q;

    // Counts consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt <= '0;
            filt_q   <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == CW'(FILT_LEN - 1)) begin
            filt_cnt <= '0;
            filt_q   <= sync_q[SYNC_STAGES-1];
        end else begin
            filt_cnt <= filt_cnt + CW'(1);
        end
    end

    assign raw = filt_q;
`else
    assign raw = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= 1'b0;
            rise <= 1'b0;
        end else begin
            s    <= raw;
            rise <= raw & ~s;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: reports high time (cmp) and period-1 (top) in generator encoding.
// Optional input glitch filter enabled by defining PWM_CAP_FILT_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int W           = PWM_W,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pwm_in,
    output logic [W-1:0] cmp_out,
    output logic [W-1:0] top_out,
    output logic         valid,
    output logic         stuck,
    output logic         level
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic s, rise;

    pwm_in_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .s     (s),
        .rise  (rise)
    );

    assign level = s;

    cap_state_t   state, state_nxt;
    logic [W-1:0] per_cnt, per_nxt, hi_cnt, hi_nxt;
    logic [W-1:0] rpt_cmp, rpt_cmp_nxt, rpt_top, rpt_top_nxt;
    logic         rpt_vld, rpt_vld_nxt, stuck_int, stuck_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            rpt_cmp   <= '0;
            rpt_top   <= '0;
            rpt_vld   <= 1'b0;
            stuck_int <= 1'b0;
        end else begin
            state     <= state_nxt;
            per_cnt   <= per_nxt;
            hi_cnt    <= hi_nxt;
            rpt_cmp   <= rpt_cmp_nxt;
            rpt_top   <= rpt_top_nxt;
            rpt_vld   <= rpt_vld_nxt;
            stuck_int <= stuck_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        per_nxt     = per_cnt;
        hi_nxt      = hi_cnt;
        rpt_cmp_nxt = rpt_cmp;
        rpt_top_nxt = rpt_top;
        rpt_vld_nxt = 1'b0;
        stuck_nxt   = stuck_int;
        if (!en) begin
            state_nxt = IDLE;
            per_nxt   = '0;
            hi_nxt    = '0;
            stuck_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt = HIGH;
                        per_nxt   = CNT_ONE;
                        hi_nxt    = CNT_ONE;
                        stuck_nxt = 1'b0;
                    end
                end
                HIGH, LOW: begin
                    // Saturation is checked first so it also wins over a coincident rise.
                    if (per_cnt == CNT_MAX) begin
                        state_nxt   = IDLE;
                        per_nxt     = '0;
                        hi_nxt      = '0;
                        rpt_top_nxt = CNT_MAX;
                        rpt_cmp_nxt = s ? CNT_MAX : '0;
                        rpt_vld_nxt = 1'b1;
                        stuck_nxt   = 1'b1;
                    end else if (state == HIGH) begin
                        per_nxt = per_cnt + CNT_ONE;
                        if (s) hi_nxt    = hi_cnt + CNT_ONE;
                        else   state_nxt = LOW;
                    end else if (rise) begin
                        state_nxt   = HIGH;
                        rpt_top_nxt = per_cnt - CNT_ONE;
                        rpt_cmp_nxt = hi_cnt;
                        rpt_vld_nxt = 1'b1;
                        per_nxt     = CNT_ONE;
                        hi_nxt      = CNT_ONE;
                    end else begin
                        per_nxt = per_cnt + CNT_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output stage: cmp/top, valid and stuck all change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_out <= '0;
            top_out <= '0;
            valid   <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            valid <= rpt_vld;
            stuck <= stuck_int;
            if (rpt_vld) begin
                cmp_out <= rpt_cmp;
                top_out <= rpt_top;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: waveform segments drive a period-level model,
// a negedge monitor pops expected reports whenever valid is seen.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int W    = PWM_W;
    localparam int SYNC = 2;
    localparam int FLEN = 4;
`ifdef PWM_CAP_FILT_EN
    localparam int LAT  = SYNC + 3;
`else
    localparam int LAT  = SYNC + 2;
`endif
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0, rst = 1'b1, en = 1'b0, pwm_in = 1'b0;
    logic [W-1:0] cmp_out, top_out;
    logic         valid, stuck, level;

    pwm_capture #(.W(W), .SYNC_STAGES(SYNC), .FILT_LEN(FLEN)) dut (
        .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
        .cmp_out(cmp_out), .top_out(top_out),
        .valid(valid), .stuck(stuck), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           vc;
        logic [W-1:0] cmp;
        logic [W-1:0] top;
        logic         stk;
    } exp_t;
    exp_t sbq[$];

    int checks = 0, failures = 0;

    // Period-level model: remembers the sample index of the arming rise and of
    // the following fall; a later rise (or a too-long period) yields a report.
    bit armed = 0, f_prev = 0, filt = 0, last_raw = 0;
    int arm_k = 0, fall_k = 0, run_len = 0;

    function automatic void push_exp(int vc, int c, int t, bit stk);
        exp_t e;
        e.vc  = vc;
        e.cmp = W'(c);
        e.top = W'(t);
        e.stk = stk;
        sbq.push_back(e);
    endfunction

    function automatic void model_step(int k, bit v);
        bit fv;
`ifdef PWM_CAP_FILT_EN
        if (v == last_raw) run_len++;
        else run_len = 1;
        last_raw = v;
        if (run_len >= FLEN) filt = v;
        fv = filt;
`else
        fv = v;
`endif
        if (en) begin
            if (armed && (k - arm_k) == MAXC) begin
                push_exp(k + LAT, fv ? MAXC : 0, MAXC, 1'b1);
                armed = 0;
            end else if (fv && !f_prev) begin
                if (armed) push_exp(k + LAT, fall_k - arm_k, k - arm_k - 1, 1'b0);
                armed = 1;
                arm_k = k;
            end else if (!fv && f_prev) begin
                fall_k = k;
            end
        end
        f_prev = fv;
    endfunction

    task automatic tick(input bit v);
        pwm_in = v;
        if (!rst) model_step(cyc + 1, v);
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int hi, input int lo);
        repeat (hi) tick(1'b1);
        repeat (lo) tick(1'b0);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cmp"}, cmp_out, '0);
        check({tag, "_top"}, top_out, '0);
        check({tag, "_valid"}, W'(valid), '0);
        check({tag, "_stuck"}, W'(stuck), '0);
        check({tag, "_level"}, W'(level), '0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        while (sbq.size() > 0 && sbq[$].vc > cyc) void'(sbq.pop_back());
        armed = 0; f_prev = 0; filt = 0; last_raw = 0; run_len = 0;
        tick(1'b0);
        check_zero_outputs("mid_reset");
        repeat (n - 1) tick(1'b0);
        rst = 1'b0;
    endtask

    // Monitor: every valid must match the oldest expected report, on its cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].vc < cyc) begin
            e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_valid expected at cycle %0d cmp=%0h top=%0h, no valid observed", e.vc, e.cmp, e.top);
        end
        if (valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL spurious_valid cycle=%0d cmp=%0h top=%0h expected no valid", cyc, cmp_out, top_out);
            end else begin
                e = sbq.pop_front();
                if (e.vc != cyc || cmp_out !== e.cmp || top_out !== e.top || stuck !== e.stk) begin
                    failures++;
                    $display("FAIL report actual cyc=%0d cmp=%0h top=%0h stuck=%0b expected cyc=%0d cmp=%0h top=%0h stuck=%0b",
                             cyc, cmp_out, top_out, stuck, e.vc, e.cmp, e.top, e.stk);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        en  = 1'b1;
        repeat (4) tick(1'b0);

        // Steady 3/9 stream, then a mixed period and a 7/19 stream.
        repeat (6) period(3, 7);
        period(3, 17);
        repeat (4) period(7, 13);
        check("steady_cmp", cmp_out, W'(7));
        check("steady_top", top_out, W'(19));

        // Random periods down to the 2-cycle minimum.
        repeat (12) period($urandom_range(1, 12), $urandom_range(1, 12));

        // en dropped for 5 cycles inside a long low phase.
        repeat (3) period(3, 7);
        repeat (3) tick(1'b1);
        repeat (8) tick(1'b0);
        en = 1'b0;
        armed = 0;
        repeat (5) tick(1'b0);
        check("en_hold_cmp", cmp_out, W'(3));
        check("en_hold_top", top_out, W'(9));
        en = 1'b1;
        repeat (5) tick(1'b0);
        repeat (4) period(3, 7);

        // Reset while the capture is in its high phase.
        repeat (3) tick(1'b1);
        tick(1'b0);
        do_reset(3);
        repeat (5) tick(1'b0);
        repeat (4) period(3, 7);
        check("post_reset_cmp", cmp_out, W'(3));
        check("post_reset_top", top_out, W'(9));

        // 2-cycle low glitch inside a 10-cycle high phase.
        repeat (2) begin
            period(4, 2);
            period(4, 10);
        end
        repeat (2) period(3, 7);

        // Held high after an arming rise: saturation, then the next rise clears stuck.
        repeat (MAXC + 10) tick(1'b1);
        repeat (10) tick(1'b0);
        check("stuck_set", W'(stuck), W'(1));
        repeat (LAT + 2) tick(1'b1);
        check("stuck_cleared", W'(stuck), W'(0));
        repeat (7) tick(1'b0);
        repeat (3) period(3, 7);
        check("final_cmp", cmp_out, W'(3));

        repeat (LAT + 4) tick(1'b0);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
